ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_stream_gen_pkg.sv | 20 ++
 rtl/ov7670_stream_gen_if.sv | 9 +
 rtl/ov7670_stream_gen_pattern_gen.sv | 25 ++
 rtl/ov7670_stream_gen.sv | 156 +++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_stream_gen_pkg.sv
// Shared types and constants for the OV7670 stream generator.
package ov7670_stream_gen_pkg;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FLAT  = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] Y_BLACK        = 8'h10;
  localparam logic [7:0] Y_WHITE        = 8'hEB;
  localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Parallel camera bus as seen between the sensor side and the receiver.
interface ov7670_stream_gen_if;
  logic       cam_VSYNC;
  logic       cam_HREF;
  logic [7:0] cam_D;

  modport master (output cam_VSYNC, output cam_HREF, output cam_D);
  modport slave  (input  cam_VSYNC, input  cam_HREF, input  cam_D);
endinterface

// File: rtl/ov7670_stream_gen_pattern_gen.sv
// Test-pattern luma generator: pure function of pattern, pixel position
// and frame number. Kept standalone so other video outputs can share it.
module cam_pattern_gen
  import ov7670_stream_gen_pkg::*;
(
  input  pattern_e   pattern,
  input  logic [7:0] h,
  input  logic [7:0] v,
  input  logic [7:0] frame_cnt,
  output logic [7:0] y
);

  // Select the luma value for the requested pattern.
  always_comb begin
    y = Y_BLACK;
    case (pattern)
      PAT_HRAMP: y = h;
      PAT_VRAMP: y = v;
      PAT_CHECK: y = (h[3] ^ v[3]) ? Y_WHITE : Y_BLACK;
      PAT_FLAT:  y = frame_cnt;
      default:   y = Y_BLACK;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 video-source model: emits VSYNC/HREF/D8 as a YUV422 byte stream,
// one byte per clock, so a camera receiver can run without a sensor.
module ov7670_stream_gen
  import ov7670_stream_gen_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 784,
  parameter int FRAME_HEIGHT = 510,
  parameter int V_OFFSET     = 20,
  parameter int VSYNC_LINES  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  ov7670_stream_gen_if.master   cam,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam int BYTES_PER_LINE = 2 * FRAME_WIDTH;
  localparam int BYTE_W = $clog2(BYTES_PER_LINE);
  localparam int LINE_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST    = BYTE_W'(BYTES_PER_LINE - 1);
  localparam logic [BYTE_W-1:0] ACTIVE_BYTES = BYTE_W'(2 * IMAGE_WIDTH);
  localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(FRAME_HEIGHT - 1);
  localparam logic [LINE_W-1:0] VS_END       = LINE_W'(VSYNC_LINES);
  localparam logic [LINE_W-1:0] ACT_START    = LINE_W'(V_OFFSET);
  // One extra bit: the end of the active region may equal FRAME_HEIGHT.
  localparam logic [LINE_W:0]   ACT_END      = (LINE_W+1)'(V_OFFSET + IMAGE_HEIGHT);

  if (IMAGE_WIDTH >= FRAME_WIDTH) begin : g_bad_width
    $error("IMAGE_WIDTH must be smaller than FRAME_WIDTH");
  end
  if (VSYNC_LINES >= V_OFFSET) begin : g_bad_vsync
    $error("VSYNC_LINES must be smaller than V_OFFSET");
  end
  if (V_OFFSET + IMAGE_HEIGHT > FRAME_HEIGHT) begin : g_bad_height
    $error("V_OFFSET + IMAGE_HEIGHT must not exceed FRAME_HEIGHT");
  end

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  pattern_e           pat_q, pat_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [7:0]         data_q, data_d;
  logic               frame_done_q, frame_done_d;

  logic               run_d;
  logic [7:0]         h_d, v_d, y_d;

  // Sequencing: start on enable, count bytes/lines, decide at frame end
  // whether to continue with a freshly latched pattern or stop.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    line_cnt_d  = line_cnt_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_RUN;
          byte_cnt_d = '0;
          line_cnt_d = '0;
          pat_d      = pattern_e'(pattern_sel);
        end
      end
      ST_RUN: begin
        if (byte_cnt_q == BYTE_LAST) begin
          byte_cnt_d = '0;
          if (line_cnt_q == LINE_LAST) begin
            line_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (enable) begin
              pat_d = pattern_e'(pattern_sel);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            line_cnt_d = line_cnt_q + LINE_W'(1);
          end
        end else begin
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel coordinates of the byte about to be presented.
  assign h_d = 8'(byte_cnt_d[BYTE_W-1:1]);
  assign v_d = 8'(line_cnt_d) - 8'(V_OFFSET);

  cam_pattern_gen u_pattern (
    .pattern   (pat_d),
    .h         (h_d),
    .v         (v_d),
    .frame_cnt (frame_cnt_d),
    .y         (y_d)
  );

  // Bus decode from the next-state counters so registered outputs line up
  // with the counters without extra latency.
  always_comb begin
    run_d        = (state_d == ST_RUN);
    vsync_d      = run_d && (line_cnt_d < VS_END);
    href_d       = run_d && (line_cnt_d >= ACT_START) &&
                   ({1'b0, line_cnt_d} < ACT_END) &&
                   (byte_cnt_d < ACTIVE_BYTES);
    data_d       = 8'h00;
    if (href_d) begin
      data_d = byte_cnt_d[0] ? CHROMA_NEUTRAL : y_d;
    end
    frame_done_d = run_d && (byte_cnt_d == BYTE_LAST) && (line_cnt_d == LINE_LAST);
  end

  // State, counters and registered bus outputs; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      line_cnt_q   <= '0;
      pat_q        <= PAT_HRAMP;
      frame_cnt_q  <= 8'h00;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pat_q        <= pat_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cam.cam_VSYNC = vsync_q;
  assign cam.cam_HREF  = href_q;
  assign cam.cam_D     = data_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: small-frame instance for timing/patterns,
// medium-frame instance for the checkerboard geometry.
module tb_ov7670_stream_gen;

  localparam int IW = 4, IH = 2, FW = 6, FH = 6, VO = 3, VS = 1;
  localparam int FCLK = 2 * FW * FH;
  localparam int IW2 = 16, IH2 = 16, FW2 = 20, FH2 = 20, VO2 = 2, VS2 = 1;
  localparam int FCLK2 = 2 * FW2 * FH2;

  logic       clk = 1'b0;
  logic       rst, enable, enable2;
  logic [1:0] pattern_sel, pattern_sel2;
  logic       frame_done, frame_done2, busy, busy2;
  logic [7:0] frame_cnt, frame_cnt2;

  ov7670_stream_gen_if cam1 ();
  ov7670_stream_gen_if cam2 ();

  ov7670_stream_gen #(
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .FRAME_WIDTH(FW),
    .FRAME_HEIGHT(FH), .V_OFFSET(VO), .VSYNC_LINES(VS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .cam(cam1.master), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  ov7670_stream_gen #(
    .IMAGE_WIDTH(IW2), .IMAGE_HEIGHT(IH2), .FRAME_WIDTH(FW2),
    .FRAME_HEIGHT(FH2), .V_OFFSET(VO2), .VSYNC_LINES(VS2)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .pattern_sel(pattern_sel2),
    .cam(cam2.master), .frame_done(frame_done2), .frame_cnt(frame_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] dbuf  [FCLK];
  logic [7:0] dbuf2 [FCLK2];

  typedef struct packed {
    logic       vs;
    logic       href;
    logic [7:0] d;
    logic       done;
  } exp_t;

  // Expected bus values for clock k of a frame, from the frame geometry.
  function automatic exp_t model(input int k, input int p, input int fc,
                                 input int iw, input int ih, input int fw,
                                 input int fh, input int vo, input int vs);
    exp_t e;
    int line, b, h, v, y;
    line   = k / (2 * fw);
    b      = k % (2 * fw);
    h      = b / 2;
    v      = line - vo;
    e.vs   = (line < vs);
    e.href = (line >= vo) && (line < vo + ih) && (b < 2 * iw);
    case (p)
      0:       y = h & 255;
      1:       y = v & 255;
      2:       y = (((h / 8) % 2) != (((v & 255) / 8) % 2)) ? 235 : 16;
      default: y = fc & 255;
    endcase
    if (!e.href)        e.d = 8'h00;
    else if (b % 2 == 1) e.d = 8'h80;
    else                 e.d = 8'(y);
    e.done = (k == 2 * fw * fh - 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input int fc);
    chk({tag, " vsync"}, cam1.cam_VSYNC, 0);
    chk({tag, " href"}, cam1.cam_HREF, 0);
    chk({tag, " d"}, cam1.cam_D, 0);
    chk({tag, " done"}, frame_done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_cnt"}, frame_cnt, fc);
  endtask

  // One full frame on the small instance, checked every clock. Inputs are
  // changed right after sampling; pattern/enable churn mid-frame must not
  // alter the frame. drop_k >= 0 forces enable low from that clock.
  task automatic run_frame(input int p, input int fc, input int next_en,
                           input int next_pat, input int drop_k);
    exp_t e;
    for (int k = 0; k < FCLK; k++) begin
      @(negedge clk);
      e = model(k, p, fc, IW, IH, FW, FH, VO, VS);
      chk($sformatf("vsync p%0d k%0d", p, k), cam1.cam_VSYNC, e.vs);
      chk($sformatf("href p%0d k%0d", p, k), cam1.cam_HREF, e.href);
      chk($sformatf("d p%0d k%0d", p, k), cam1.cam_D, e.d);
      chk($sformatf("done k%0d", k), frame_done, e.done);
      chk($sformatf("busy k%0d", k), busy, 1);
      chk($sformatf("frame_cnt k%0d", k), frame_cnt, fc);
      dbuf[k] = cam1.cam_D;
      if (k == FCLK - 1) begin
        enable      = next_en[0];
        pattern_sel = next_pat[1:0];
      end else if (k == drop_k) begin
        enable = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        pattern_sel = 2'($urandom_range(0, 3));
        if (drop_k < 0) enable = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, np, fc;
    exp_t e;
    logic [7:0] tbl [8];
    tbl = '{8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03, 8'h80};

    // Reset and idle
    rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
    enable2 = 1'b0; pattern_sel2 = 2'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset", 0);
    chk("reset busy2", busy2, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      chk_idle("idle", 0);
    end

    // First frame, horizontal ramp, enable held
    fc = 0;
    enable = 1'b1; pattern_sel = 2'd0;
    p  = 0;
    np = $urandom_range(0, 3);
    run_frame(p, fc, 1, np, -1);
    for (int i = 0; i < 8; i++) chk($sformatf("p0 line3 byte%0d", i), dbuf[36 + i], tbl[i]);
    fc++; p = np;

    // Back-to-back random-pattern frames, stopping after the last
    for (int f = 0; f < 4; f++) begin
      np = $urandom_range(0, 3);
      run_frame(p, fc, (f < 3) ? 1 : 0, np, -1);
      fc++; p = np;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk_idle("after stop", fc);
    end

    // Graceful stop: enable dropped at clock 40
    p = $urandom_range(0, 3);
    enable = 1'b1; pattern_sel = 2'(p);
    run_frame(p, fc, 0, 0, 40);
    fc++;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk_idle("graceful stop", fc);
    end

    // Asynchronous reset while HREF is high
    enable = 1'b1; pattern_sel = 2'd0;
    for (int k = 0; k <= 40; k++) @(negedge clk);
    chk("pre-reset href", cam1.cam_HREF, 1);
    #1 rst = 1'b1;
    #1;
    chk("async rst href", cam1.cam_HREF, 0);
    chk("async rst d", cam1.cam_D, 0);
    chk("async rst vsync", cam1.cam_VSYNC, 0);
    chk("async rst busy", busy, 0);
    chk("async rst frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; pattern_sel = 2'd3;
    fc = 0;
    run_frame(3, fc, 0, 0, -1);
    fc++;

    // 256 frames: frame_cnt wraps back to 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fc = 0;
    p = $urandom_range(0, 3);
    enable = 1'b1; pattern_sel = 2'(p);
    for (int f = 0; f < 256; f++) begin
      np = $urandom_range(0, 3);
      run_frame(p, fc, (f < 255) ? 1 : 0, np, -1);
      fc = (fc + 1) % 256; p = np;
    end
    @(negedge clk);
    chk("wrap frame_cnt", frame_cnt, 0);
    chk("wrap busy", busy, 0);

    // Checkerboard geometry on the larger instance
    enable2 = 1'b1; pattern_sel2 = 2'd2;
    for (int k = 0; k < FCLK2; k++) begin
      @(negedge clk);
      e = model(k, 2, 0, IW2, IH2, FW2, FH2, VO2, VS2);
      chk($sformatf("chk href k%0d", k), cam2.cam_HREF, e.href);
      chk($sformatf("chk d k%0d", k), cam2.cam_D, e.d);
      dbuf2[k] = cam2.cam_D;
      if (k == 0) begin
        enable2 = 1'b0;
        pattern_sel2 = 2'd0;
      end
    end
    chk("chk line0 pix8", dbuf2[VO2 * 2 * FW2 + 16], 8'hEB);
    chk("chk line0 pix0", dbuf2[VO2 * 2 * FW2], 8'h10);
    chk("chk line8 pix8", dbuf2[(VO2 + 8) * 2 * FW2 + 16], 8'h10);
    chk("chk chroma", dbuf2[VO2 * 2 * FW2 + 17], 8'h80);
    @(negedge clk);
    chk("chk frame_cnt2", frame_cnt2, 1);
    chk("chk busy2", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
